// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: time limits and output widths shared by the stopwatch control unit, datapath and display
package stopwatch_pkg;
  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int MSEC_W   = 7;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } stopwatch_time_t;
endpackage

// File: rtl/stopwatch_dp_time_counter.sv
// time_counter: one wrapping stage of the stopwatch chain; carry is combinational so a full rollover lands on one edge
module time_counter #(
  parameter int MAX   = 99,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carry
);
  assign o_carry = i_tick && o_count == WIDTH'(MAX);
  always_ff @(posedge clk or posedge reset)
    if (reset) o_count <= '0;
    else if (i_clear) o_count <= '0;
    else if (i_tick) o_count <= o_carry ? '0 : o_count + 1'b1;
endmodule

// File: rtl/stopwatch_dp.sv
// stopwatch_dp: tick divider plus msec/sec/min/hour counter chain.
// Define STOPWATCH_HOUR_EN to include the hour stage; otherwise minutes wrap and 59:59.99 rolls to 00:00.00.
module stopwatch_dp
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic              i_clear,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  logic [DW-1:0] div;
  logic tick, msec_carry, sec_carry, min_carry;
  assign tick = i_run && !i_clear && div == DW'(DIV - 1);
  // holding div while paused keeps the sub-tick phase across stop/resume
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div    <= '0;
      o_tick <= 1'b0;
    end else begin
      div    <= i_clear || tick ? '0 : i_run ? div + 1'b1 : div;
      o_tick <= tick;
    end
  time_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
    .clk(clk), .reset(reset), .i_tick(tick), .i_clear(i_clear),
    .o_count(o_msec), .o_carry(msec_carry)
  );
  time_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .i_tick(msec_carry), .i_clear(i_clear),
    .o_count(o_sec), .o_carry(sec_carry)
  );
  time_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clk(clk), .reset(reset), .i_tick(sec_carry), .i_clear(i_clear),
    .o_count(o_min), .o_carry(min_carry)
  );
`ifdef STOPWATCH_HOUR_EN
  logic unused_hour_carry;
  time_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
    .clk(clk), .reset(reset), .i_tick(min_carry), .i_clear(i_clear),
    .o_count(o_hour), .o_carry(unused_hour_carry)
  );
`else
  logic unused_min_carry;
  assign unused_min_carry = min_carry;
  assign o_hour = '0;
`endif
endmodule

// File: tb/tb_stopwatch_dp.sv
// tb_stopwatch_dp: table-driven scoreboard bench for stopwatch_dp at DIV=10; honours STOPWATCH_HOUR_EN
module tb_stopwatch_dp;
  logic clk = 1'b0, reset = 1'b1, i_run = 1'b0, i_clear = 1'b0;
  logic [6:0] o_msec;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic o_tick;
  int checks = 0, failures = 0;
  typedef struct {
    string name;
    logic  run;
    logic  clear;
    int    n;
    int    msec, sec, min, hour, ticks;
  } vec_t;
  vec_t vecs[10];
  vec_t sb[$];

  always #5 clk = ~clk;

  stopwatch_dp #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_clear(i_clear),
    .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_tick(o_tick)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    int ticks;
    ticks = 0;
    sb.push_back(v);
    i_run   = v.run;
    i_clear = v.clear;
    repeat (v.n) begin
      @(negedge clk);
      ticks += int'(o_tick);
    end
    e = sb.pop_front();
    check({e.name, " msec"}, int'(o_msec), e.msec);
    check({e.name, " sec"}, int'(o_sec), e.sec);
    check({e.name, " min"}, int'(o_min), e.min);
    check({e.name, " hour"}, int'(o_hour), e.hour);
    check({e.name, " ticks"}, ticks, e.ticks);
  endtask

  task automatic check_zero(input string name);
    check({name, " msec"}, int'(o_msec), 0);
    check({name, " sec"}, int'(o_sec), 0);
    check({name, " min"}, int'(o_min), 0);
    check({name, " hour"}, int'(o_hour), 0);
    check({name, " tick"}, int'(o_tick), 0);
  endtask

  initial begin
    vecs[0] = '{"run10",       1'b1, 1'b0, 10,  1, 0, 0, 0, 1};
    vecs[1] = '{"run1000",     1'b1, 1'b0, 990, 0, 1, 0, 0, 99};
    vecs[2] = '{"clear",       1'b0, 1'b1, 1,   0, 0, 0, 0, 0};
    vecs[3] = '{"pre_pause",   1'b1, 1'b0, 5,   0, 0, 0, 0, 0};
    vecs[4] = '{"pause",       1'b0, 1'b0, 20,  0, 0, 0, 0, 0};
    vecs[5] = '{"resume",      1'b1, 1'b0, 5,   1, 0, 0, 0, 1};
    vecs[6] = '{"dropout_a",   1'b1, 1'b0, 8,   1, 0, 0, 0, 0};
    vecs[7] = '{"dropout_gap", 1'b0, 1'b0, 1,   1, 0, 0, 0, 0};
    vecs[8] = '{"dropout_b",   1'b1, 1'b0, 1,   1, 0, 0, 0, 0};
    vecs[9] = '{"dropout_c",   1'b1, 1'b0, 1,   2, 0, 0, 0, 1};
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    foreach (vecs[i]) apply(vecs[i]);

    // clear while run is high and the divider is about to tick
    apply('{"clr0",      1'b0, 1'b1, 1,    0, 0, 0, 0, 0});
    apply('{"to_5_37",   1'b1, 1'b0, 5379, 37, 5, 0, 0, 537});
    apply('{"run_clear", 1'b1, 1'b1, 1,    0, 0, 0, 0, 0});
    apply('{"after_clr", 1'b0, 1'b0, 1,    0, 0, 0, 0, 0});

    // async reset with divider at 7 and three seconds elapsed
    apply('{"clr1",      1'b0, 1'b1, 1,    0, 0, 0, 0, 0});
    apply('{"to_3s",     1'b1, 1'b0, 3007, 0, 3, 0, 0, 300});
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    apply('{"post_rst9",  1'b1, 1'b0, 9, 0, 0, 0, 0, 0});
    apply('{"post_rst10", 1'b1, 1'b0, 1, 1, 0, 0, 0, 1});

    // preload 59:59.99 with the divider at 0, then one tick
    apply('{"align",     1'b1, 1'b0, 9, 1, 0, 0, 0, 0});
    apply('{"align_tk",  1'b1, 1'b0, 1, 2, 0, 0, 0, 1});
    i_run = 1'b0;
    force dut.u_msec.o_count = 7'd99;
    force dut.u_sec.o_count  = 6'd59;
    force dut.u_min.o_count  = 6'd59;
    @(negedge clk);
    release dut.u_msec.o_count;
    release dut.u_sec.o_count;
    release dut.u_min.o_count;
`ifdef STOPWATCH_HOUR_EN
    apply('{"roll_59m",  1'b1, 1'b0, 10, 0, 0, 0, 1, 1});
    i_run = 1'b0;
    force dut.u_msec.o_count = 7'd99;
    force dut.u_sec.o_count  = 6'd59;
    force dut.u_min.o_count  = 6'd59;
    force dut.u_hour.o_count = 5'd23;
    @(negedge clk);
    release dut.u_msec.o_count;
    release dut.u_sec.o_count;
    release dut.u_min.o_count;
    release dut.u_hour.o_count;
    apply('{"roll_23h",  1'b1, 1'b0, 10, 0, 0, 0, 0, 1});
`else
    apply('{"roll_59m",  1'b1, 1'b0, 10, 0, 0, 0, 0, 1});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stopwatch_dp.md
# stopwatch_dp

Stopwatch datapath: turns the control unit's `o_run`/`o_clear` levels into elapsed-time counts (centiseconds, seconds, minutes, hours). It sits directly downstream of the stopwatch control FSM and upstream of the FND/display formatter.

## Interface
- `CLK_FREQ`, default 100_000_000: input clock frequency in Hz.
- `TICK_HZ`, default 100: count rate in Hz. The divide ratio `DIV = CLK_FREQ/TICK_HZ` must be an integer ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `i_run`  in  1  level: count while high, hold while low.
- `i_clear`  in  1  level: zero all counts while high.
- `o_msec`  out  7  centiseconds, 0–99.
- `o_sec`  out  6  seconds, 0–59.
- `o_min`  out  6  minutes, 0–59.
- `o_hour`  out  5  hours, 0–23.
- `o_tick`  out  1  one-cycle pulse on each counted tick (qualified by run).

## Operation
- Tick divider:
  - Counts 0..DIV-1 while `i_run`=1 and `i_clear`=0.
  - At DIV-1 it wraps to 0 and asserts the internal tick for that cycle.
  - When `i_run`=0, the divider holds its value. Pause therefore keeps sub-tick phase, so stop/resume loses no time.
- Counter chain: msec → sec → min → hour.
  - Each stage increments on its input tick.
  - At its max value (99/59/59/23), a stage wraps to 0 and emits a carry in the same cycle.
  - Carry is combinational, so a full rollover (e.g. 99→0, 59→0, 59→0, 23→0) happens on a single clock edge.
- Hour wraps 23→0 with no overflow flag.
- `i_clear`=1 synchronously zeroes the divider and every counter on the next edge.
  - Clear has priority over `i_run` when both are high.
  - `o_tick` is suppressed while clear is high.
- `i_run`=0 and `i_clear`=0: all state holds.
- Arithmetic is unsigned. Divider width is `$clog2(DIV)`. Count values are never outside their range, including after reset.
- Reset (async): divider 0, all counts 0, `o_tick` 0. Reset asserted mid-count zeroes everything immediately. Counting resumes from 0 on the first edge after release if `i_run`=1.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- From `i_run` rising at edge N (divider at 0):
  - First tick occurs on edge N+DIV-1, counted from the first edge that samples `i_run`=1.
  - `o_msec` increments at the same edge that `o_tick` goes high.
  - `o_tick` is high for exactly one cycle.
- `i_clear` sampled high at edge N: outputs read 0 after edge N.
- Tick rate = `CLK_FREQ/TICK_HZ` clocks per count, exactly.
- One-cycle `i_run` dropout: the divider pauses for one cycle and elapsed count is delayed by one clock.

## Configuration
- `STOPWATCH_HOUR_EN` defined:
  - Hour stage present.
  - Minute carry feeds hour.
  - Rollover from 23:59:59.99 goes to 00:00:00.00.
- Not defined:
  - Hour stage removed; `o_hour` tied to 0.
  - Minute wraps 59→0 and the carry is discarded.
  - Rollover from 59:59.99 goes to 00:00.00.

## Structure
- Shared package `stopwatch_pkg`:
  - Limits `MSEC_MAX`=99, `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23.
  - Output width constants 7/6/6/5.
  - The same package is consumed by the CU and display blocks.
- One natural sub-module, `time_counter`:
  - Parameters `MAX`, `WIDTH`.
  - Ports `clk`, `reset`, `i_tick`, `i_clear`, `o_count`, `o_carry`.
  - Instantiated once per stage.
- The divider is written inline in `stopwatch_dp`.

## Test plan
Bench uses CLK_FREQ=1000, TICK_HZ=100 (DIV=10).
- Reset then `i_run`=1 for 10 clocks → `o_msec`=1, exactly one `o_tick` pulse.
- Run 1000 clocks → `o_msec`=0, `o_sec`=1 (99→0 with carry on the same edge).
- Run 5 clocks, drop `i_run` for 20 clocks, run 5 clocks → `o_msec`=1 (phase kept across the pause).
- Preload near max by running to 59:59.99, one more tick:
  - With `STOPWATCH_HOUR_EN`: `o_hour`=1, min/sec/msec=0.
  - Without: all outputs 0.
- `i_run`=1 and `i_clear`=1 together for 1 clock at count 00:05.37 → all 0 next cycle, no `o_tick`.
- Assert `reset` mid-tick (divider=7, `o_sec`=3) → all outputs 0 immediately. After release, first tick comes 10 clocks later.
